// File: rtl/ast_feed_sched.sv
// -----------------------------------------------------------------------------
// ast_feed_sched
// Sequencing controller for a bank of parallel-loadable lane FIFOs feeding a
// systolic array. Per tile: one broadcast parallel load, then per-lane pops
// (diagonally skewed so operands arrive wavefront-aligned), one drain cycle,
// then a pointer clear with a completion pulse.
//
// Configuration macro: AST_FEED_SKEW_EN
//   defined   : lane i pops during steps t = i .. i+DEPTH-1 (diagonal skew),
//               FEED lasts DEPTH+LANES-1 cycles.
//   undefined : all lanes pop together for t = 0 .. DEPTH-1,
//               FEED lasts DEPTH cycles.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst_n         asynchronous active-low reset
//   i_start         tile request, sampled only in IDLE
//   i_abort         synchronous early termination of the current tile
//   i_stall         downstream backpressure, freezes the feed
//   i_fifo_empty    per-lane empty flags
//   o_fifo_load     broadcast parallel_load strobe
//   o_fifo_pop      per-lane pop strobes
//   o_fifo_rst_ptr  broadcast pointer clear
//   o_lane_valid    lane data_out holds fresh data this cycle
//   o_busy          high in every state except IDLE
//   o_done          one-cycle pulse at tile end
//   o_err           sticky: pop issued to an empty lane
//   o_tile_count    completed tiles, wraps at 2^16
// -----------------------------------------------------------------------------
module ast_feed_sched #(
    parameter int LANES = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_stall,
    input  logic [LANES-1:0] i_fifo_empty,
    output logic             o_fifo_load,
    output logic [LANES-1:0] o_fifo_pop,
    output logic             o_fifo_rst_ptr,
    output logic [LANES-1:0] o_lane_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [15:0]      o_tile_count
);

    localparam int TW = $clog2(DEPTH + LANES);
`ifdef AST_FEED_SKEW_EN
    localparam int T_LAST = DEPTH + LANES - 2;
`else
    localparam int T_LAST = DEPTH - 1;
`endif
    localparam logic [TW-1:0] T_LAST_W = TW'(T_LAST);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [TW-1:0]    r_t;
    logic [TW-1:0]    w_t_nx;
    logic [LANES-1:0] w_pop;

    logic             r_load;
    logic             r_rst_ptr;
    logic             r_done;
    logic             r_busy;
    logic             r_err;
    logic [LANES-1:0] r_lane_valid;
    logic [15:0]      r_tile_count;

    // Pop strobes: combinational so stall/abort suppress pops in the same cycle.
    always_comb begin
        w_pop = '0;
        if ((r_state == S_FEED) && !i_stall && !i_abort) begin
            for (int i = 0; i < LANES; i++) begin
`ifdef AST_FEED_SKEW_EN
                if ((int'(r_t) >= i) && ((int'(r_t) - i) < DEPTH)) begin
                    w_pop[i] = 1'b1;
                end else begin
                    w_pop[i] = 1'b0;
                end
`else
                if (int'(r_t) < DEPTH) begin
                    w_pop[i] = 1'b1;
                end else begin
                    w_pop[i] = 1'b0;
                end
`endif
            end
        end else begin
            w_pop = '0;
        end
    end

    // Next-state and step-counter logic.
    always_comb begin
        w_state_nx = r_state;
        w_t_nx     = r_t;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nx = S_LOAD;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_LOAD: begin
                if (i_abort) begin
                    w_state_nx = S_CLEAR;
                end else begin
                    w_state_nx = S_FEED;
                    w_t_nx     = '0;
                end
            end
            S_FEED: begin
                if (i_abort) begin
                    w_state_nx = S_CLEAR;
                end else if (i_stall) begin
                    w_state_nx = S_FEED;
                end else if (r_t == T_LAST_W) begin
                    w_state_nx = S_DRAIN;
                end else begin
                    w_t_nx = r_t + TW'(1);
                end
            end
            S_DRAIN: begin
                // Abort and normal completion both lead to CLEAR from here.
                w_state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                w_state_nx = S_IDLE;
                w_t_nx     = '0;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_t_nx     = '0;
            end
        endcase
    end

    // State and step counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_t     <= '0;
        end else begin
            r_state <= w_state_nx;
            r_t     <= w_t_nx;
        end
    end

    // Registered strobes decoded from the next state so they align with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_load       <= 1'b0;
            r_rst_ptr    <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_lane_valid <= '0;
            r_tile_count <= 16'd0;
        end else begin
            r_load       <= (w_state_nx == S_LOAD);
            r_rst_ptr    <= (w_state_nx == S_CLEAR);
            r_done       <= (w_state_nx == S_CLEAR);
            r_busy       <= (w_state_nx != S_IDLE);
            r_lane_valid <= w_pop;
            if (w_state_nx == S_CLEAR) begin
                r_tile_count <= r_tile_count + 16'd1;
            end else begin
                r_tile_count <= r_tile_count;
            end
        end
    end

    // Sticky underflow flag, cleared when a new tile is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_err <= 1'b0;
        end else if (|(w_pop & i_fifo_empty)) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign o_fifo_load    = r_load;
    assign o_fifo_pop     = w_pop;
    assign o_fifo_rst_ptr = r_rst_ptr;
    assign o_lane_valid   = r_lane_valid;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_tile_count   = r_tile_count;

endmodule

// File: tb/tb_ast_feed_sched.sv
// -----------------------------------------------------------------------------
// tb_ast_feed_sched
// Directed bench for ast_feed_sched with LANES=4, DEPTH=4. Each scenario is a
// per-cycle table of stimulus and hand-computed expected outputs; cycle 0 is
// the cycle whose closing edge samples start, cycle 1 is the LOAD cycle.
// Expected tables follow AST_FEED_SKEW_EN so the bench matches either build.
// -----------------------------------------------------------------------------
module tb_ast_feed_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       stall;
    logic [3:0] fifo_empty;
    logic       fifo_load;
    logic [3:0] fifo_pop;
    logic       fifo_rst_ptr;
    logic [3:0] lane_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic [15:0] tile_count;

    int n_checks = 0;
    int n_errors = 0;

    bit [3:0] e_pop   [32];
    bit       e_load  [32];
    bit       e_done  [32];
    bit       e_busy  [32];
    bit       e_err   [32];
    bit       s_start [32];
    bit       s_stall [32];
    bit       s_abort [32];
    bit [3:0] s_empty [32];

    always #5 clk = ~clk;

    ast_feed_sched #(.LANES(4), .DEPTH(4)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_abort        (abort),
        .i_stall        (stall),
        .i_fifo_empty   (fifo_empty),
        .o_fifo_load    (fifo_load),
        .o_fifo_pop     (fifo_pop),
        .o_fifo_rst_ptr (fifo_rst_ptr),
        .o_lane_valid   (lane_valid),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err),
        .o_tile_count   (tile_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_tab();
        for (int i = 0; i < 32; i++) begin
            e_pop[i] = 4'h0; e_load[i] = 1'b0; e_done[i] = 1'b0;
            e_busy[i] = 1'b0; e_err[i] = 1'b0; s_start[i] = 1'b0;
            s_stall[i] = 1'b0; s_abort[i] = 1'b0; s_empty[i] = 4'h0;
        end
    endtask

    task automatic set_busy(input int a, input int b);
        for (int i = a; i <= b; i++) e_busy[i] = 1'b1;
    endtask

    task automatic set_err(input int a, input int b);
        for (int i = a; i <= b; i++) e_err[i] = 1'b1;
    endtask

    task automatic set_pop_f(input int a, input int b);
        for (int i = a; i <= b; i++) e_pop[i] = 4'hF;
    endtask

    // Skewed pop diagonal for a tile whose LOAD cycle is l.
    task automatic skew_pops(input int l);
        e_pop[l+1] = 4'h1; e_pop[l+2] = 4'h3; e_pop[l+3] = 4'h7; e_pop[l+4] = 4'hF;
        e_pop[l+5] = 4'hE; e_pop[l+6] = 4'hC; e_pop[l+7] = 4'h8;
    endtask

    task automatic run_table(input string name, input int n);
        bit [3:0] prev;
        prev = 4'h0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start      = s_start[c];
            stall      = s_stall[c];
            abort      = s_abort[c];
            fifo_empty = s_empty[c];
            #1;
            check($sformatf("%s.pop@%0d", name, c),     32'(fifo_pop),     32'(e_pop[c]));
            check($sformatf("%s.valid@%0d", name, c),   32'(lane_valid),   32'(prev));
            check($sformatf("%s.load@%0d", name, c),    32'(fifo_load),    32'(e_load[c]));
            check($sformatf("%s.done@%0d", name, c),    32'(done),         32'(e_done[c]));
            check($sformatf("%s.rstptr@%0d", name, c),  32'(fifo_rst_ptr), 32'(e_done[c]));
            check($sformatf("%s.busy@%0d", name, c),    32'(busy),         32'(e_busy[c]));
            check($sformatf("%s.err@%0d", name, c),     32'(err),          32'(e_err[c]));
            prev = e_pop[c];
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0; fifo_empty = 4'h0;
        repeat (2) @(negedge clk);
        check("rst.load",  32'(fifo_load),    32'd0);
        check("rst.pop",   32'(fifo_pop),     32'd0);
        check("rst.rstp",  32'(fifo_rst_ptr), 32'd0);
        check("rst.valid", 32'(lane_valid),   32'd0);
        check("rst.busy",  32'(busy),         32'd0);
        check("rst.done",  32'(done),         32'd0);
        check("rst.err",   32'(err),          32'd0);
        check("rst.tc",    32'(tile_count),   32'd0);
        rst_n = 1'b1;

        // Nominal tile.
        clr_tab();
        s_start[0] = 1'b1; e_load[1] = 1'b1;
`ifdef AST_FEED_SKEW_EN
        skew_pops(1); e_done[10] = 1'b1; set_busy(1, 10);
        run_table("nominal", 12);
`else
        set_pop_f(2, 5); e_done[7] = 1'b1; set_busy(1, 7);
        run_table("nominal", 9);
`endif
        check("nominal.tc", 32'(tile_count), 32'd1);

        // Two stall cycles starting at FEED t=3 (cycle 5).
        clr_tab();
        s_start[0] = 1'b1; e_load[1] = 1'b1; s_stall[5] = 1'b1; s_stall[6] = 1'b1;
`ifdef AST_FEED_SKEW_EN
        e_pop[2] = 4'h1; e_pop[3] = 4'h3; e_pop[4] = 4'h7; e_pop[7] = 4'hF;
        e_pop[8] = 4'hE; e_pop[9] = 4'hC; e_pop[10] = 4'h8;
        e_done[12] = 1'b1; set_busy(1, 12);
        run_table("stall", 14);
`else
        set_pop_f(2, 4); e_pop[7] = 4'hF; e_done[9] = 1'b1; set_busy(1, 9);
        run_table("stall", 11);
`endif
        check("stall.tc", 32'(tile_count), 32'd2);

        // Abort at FEED t=2 (cycle 4), with stall also high: abort wins.
        clr_tab();
        s_start[0] = 1'b1; e_load[1] = 1'b1; s_abort[4] = 1'b1; s_stall[4] = 1'b1;
`ifdef AST_FEED_SKEW_EN
        e_pop[2] = 4'h1; e_pop[3] = 4'h3;
`else
        set_pop_f(2, 3);
`endif
        e_done[5] = 1'b1; set_busy(1, 5);
        run_table("abort", 7);
        check("abort.tc", 32'(tile_count), 32'd3);

        // Empty lane 2: harmless while lane 2 idle, flags err when popped.
        clr_tab();
        s_start[0] = 1'b1; e_load[1] = 1'b1; s_empty[4] = 4'b0100;
`ifdef AST_FEED_SKEW_EN
        s_empty[3] = 4'b0100;
        skew_pops(1); e_done[10] = 1'b1; set_busy(1, 10); set_err(5, 11);
        run_table("err", 12);
`else
        s_empty[1] = 4'b0100;
        set_pop_f(2, 5); e_done[7] = 1'b1; set_busy(1, 7); set_err(5, 8);
        run_table("err", 9);
`endif
        check("err.tc", 32'(tile_count), 32'd4);

        // Start held high: second tile only from IDLE; err cleared by accept.
        clr_tab();
        e_err[0] = 1'b1;
`ifdef AST_FEED_SKEW_EN
        for (int i = 0; i <= 21; i++) s_start[i] = 1'b1;
        e_load[1] = 1'b1; e_load[12] = 1'b1;
        skew_pops(1); skew_pops(12);
        e_done[10] = 1'b1; e_done[21] = 1'b1;
        set_busy(1, 10); set_busy(12, 21);
        run_table("held", 24);
`else
        for (int i = 0; i <= 15; i++) s_start[i] = 1'b1;
        e_load[1] = 1'b1; e_load[9] = 1'b1;
        set_pop_f(2, 5); set_pop_f(10, 13);
        e_done[7] = 1'b1; e_done[15] = 1'b1;
        set_busy(1, 7); set_busy(9, 15);
        run_table("held", 18);
`endif
        check("held.tc", 32'(tile_count), 32'd6);

        // Reset asserted mid-FEED clears outputs without waiting for a clock.
        clr_tab();
        s_start[0] = 1'b1; e_load[1] = 1'b1; set_busy(1, 3);
`ifdef AST_FEED_SKEW_EN
        e_pop[2] = 4'h1; e_pop[3] = 4'h3;
`else
        set_pop_f(2, 3);
`endif
        run_table("midrst", 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.pop",   32'(fifo_pop),     32'd0);
        check("midrst.valid", 32'(lane_valid),   32'd0);
        check("midrst.busy",  32'(busy),         32'd0);
        check("midrst.load",  32'(fifo_load),    32'd0);
        check("midrst.rstp",  32'(fifo_rst_ptr), 32'd0);
        check("midrst.done",  32'(done),         32'd0);
        check("midrst.tc",    32'(tile_count),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("post.busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ast_feed_sched.md
# ast_feed_sched

Sequencing controller for a bank of parallel-loadable FIFOs that feed the systolic compute array. Per tile it issues one broadcast parallel load, pops each lane FIFO with a one-cycle diagonal skew so operands arrive wavefront-aligned, then flushes the FIFO pointers and reports completion. It sits between the tile loader and the `LANES` lane FIFOs and drives their `parallel_load`, `pop` and `rst_ptr` inputs.

## Interface
- `LANES`, 8: number of lane FIFOs controlled (≥2).
- `DEPTH`, 8: entries per lane FIFO; pops issued per lane per tile.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one tile; sampled only in IDLE.
- `abort`  in  1  synchronous; ends the current tile early.
- `stall`  in  1  downstream backpressure; freezes the feed.
- `fifo_empty`  in  LANES  per-lane empty flags from the FIFOs.
- `fifo_load`  out  1  broadcast parallel_load strobe.
- `fifo_pop`  out  LANES  per-lane pop strobes.
- `fifo_rst_ptr`  out  1  broadcast pointer clear.
- `lane_valid`  out  LANES  lane FIFO data_out holds fresh data this cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at tile end.
- `err`  out  1  sticky: a pop was issued to an empty lane.
- `tile_count`  out  16  completed tiles, wraps at 2^16.

## Operation
- States: IDLE, LOAD, FEED, DRAIN, CLEAR.
- IDLE: `start`=1 → LOAD. Also clears `err`. `start` in any other state is ignored; it is not queued.
- LOAD: `fifo_load`=1 for exactly one cycle → FEED, step counter `t`=0.
- FEED: `fifo_pop[i]` = (t ≥ i) && (t − i < DEPTH) && !stall. `t` runs 0..DEPTH+LANES−2. It increments only when `stall`=0. When t = DEPTH+LANES−2 and `stall`=0, go to DRAIN.
- `stall`=1 in FEED: all pops 0, `t` holds, state holds.
- DRAIN: no pops, one cycle → CLEAR. This lets the last `lane_valid` retire.
- CLEAR: `fifo_rst_ptr`=1, `done`=1, `tile_count`+1, all for one cycle → IDLE.
- `abort`=1 in LOAD, FEED or DRAIN: go to CLEAR next cycle. Pops are 0 in the abort cycle. `done` and `tile_count` still update.
- `lane_valid[i]` = `fifo_pop[i]` registered by one cycle, matching the FIFO's registered data_out.
- `err` is set on any cycle with `fifo_pop[i]` && `fifo_empty[i]`. The pop is still driven, and the FIFO ignores it.
- `t` width is $clog2(DEPTH+LANES).

## Timing
- Reset values: state IDLE, t=0, every output 0 (including `err` and `tile_count`). Reset is effective immediately and asynchronously.
- Reset mid-tile: outputs clear immediately. The FIFOs are not sent `rst_ptr`; the system reset clears them.
- Let edge E0 be the edge that samples `start`=1. Then:
  - `fifo_load` is high in the cycle after E0.
  - FEED starts after E1.
  - `fifo_pop[0]` first rises in the cycle after E1.
  - `lane_valid[0]` first rises one cycle later.
- Unstalled tile: LOAD 1 cycle, FEED DEPTH+LANES−1 cycles, DRAIN 1, CLEAR 1.
  - `done` is high in cycle DEPTH+LANES+2 after E0 (counting the cycle after E0 as cycle 1).
  - The next `start` can be sampled on the edge that ends CLEAR's following IDLE cycle.
- Each stall cycle in FEED extends the tile by exactly one cycle.
- `stall` and `abort` high together: `abort` wins.

## Configuration
- Macro: `AST_FEED_SKEW_EN`.
- Defined: diagonal skew as described. FEED lasts DEPTH+LANES−1 cycles.
- Undefined: all lanes pop together, `fifo_pop[i]` = (t < DEPTH) && !stall for every i. FEED lasts DEPTH cycles and ends at t = DEPTH−1.

## Test plan
All cases use LANES=4, DEPTH=4, `AST_FEED_SKEW_EN` defined, unless stated.
- Reset then one `start` pulse, no stall:
  - `fifo_load` high in cycle 1.
  - `fifo_pop` over cycles 2..8 = 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - `done` high in cycle 10, `tile_count`=1, `lane_valid` equals `fifo_pop` delayed by one cycle.
- `stall` high for 2 cycles at FEED t=3 → pops 0000 for those cycles, pattern resumes at 1111, `done` in cycle 12.
- `abort` at FEED t=2 → next cycle `fifo_rst_ptr`=`done`=1, pops 0, state returns to IDLE, `tile_count` increments.
- `fifo_empty[2]`=1 forced while `fifo_pop[2]`=1 → `err`=1 and held through tile end. Next accepted `start` clears it.
- `start` held high through a tile → second tile begins only from IDLE. Exactly one `done` per accepted start, no back-to-back LOAD.
- `AST_FEED_SKEW_EN` undefined → `fifo_pop`=1111 for cycles 2..5, `done` in cycle 7. Separately, `rst` asserted mid-FEED → all outputs 0 immediately.
